// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state types and size decode helpers for the LSU memory master
// Exports: size_e (access size), state_e (FSM state), size_to_mask(), size_to_bytes()
package lsu_pkg;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

   // Length code for the memory port; depends on size only, never on the offset.
   function automatic logic [7:0] size_to_mask(size_e s);
      return s == SZ_B ? 8'h01 : s == SZ_H ? 8'h03 : s == SZ_W ? 8'h0F : 8'hFF;
   endfunction

   function automatic logic [3:0] size_to_bytes(size_e s);
      return 4'd1 << s;
   endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte lane of a doubleword and sign/zero-extends it
// Ports: rd_data (raw doubleword), off (byte offset), size, sgn (sign-extend) -> data (64b result)
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [63:0] rd_data,
   input  logic [2:0]  off,
   input  size_e       size,
   input  logic        sgn,
   output logic [63:0] data
);
   logic [63:0] lane;
   always_comb begin
      lane = rd_data >> {off, 3'b000};
      data = size == SZ_B ? {{56{sgn & lane[7]}},  lane[7:0]}  :
             size == SZ_H ? {{48{sgn & lane[15]}}, lane[15:0]} :
             size == SZ_W ? {{32{sgn & lane[31]}}, lane[31:0]} : lane;
   end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: LSU back end issuing one single-cycle memory access per request with a registered response
// Ports: clock/reset (async active-low); req_* request handshake from MEM stage;
//        resp_* registered response handshake; rd_*/we_* memory read and write port
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter logic [63:0] PMEM_BASE = 64'h8000_0000,
   parameter logic [63:0] PMEM_SIZE = 64'h0800_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_misal,
   output logic        resp_fault,
   output logic        rd_en,
   output logic [63:0] rd_addr,
   input  logic [63:0] rd_data,
   output logic        we_en,
   output logic [63:0] we_addr,
   output logic [63:0] we_data,
   output logic [7:0]  we_mask
);
   state_e      state;
   size_e       sz_c, size_q;
   logic [2:0]  off_q, amask;
   logic        sgn_q, wen_q, misal_q, fault_q;
   logic        accept, misal_c, fault_c;
   logic [64:0] end_c;
   logic [63:0] ld_data;

   assign sz_c    = size_e'(req_size);
   assign amask   = 3'(size_to_bytes(sz_c) - 4'd1);
   assign misal_c = |(req_addr[2:0] & amask);
   // 65-bit end address so an access wrapping past 2^64 is reported as a fault
   assign end_c   = {1'b0, req_addr} + {61'b0, size_to_bytes(sz_c)};
   assign fault_c = req_addr < PMEM_BASE || end_c > ({1'b0, PMEM_BASE} + {1'b0, PMEM_SIZE});

   assign req_ready  = reset && state == ST_IDLE;
   assign resp_valid = state == ST_RESP;
   assign accept     = req_valid && req_ready;

   lsu_load_align u_align (
      .rd_data(rd_data),
      .off    (off_q),
      .size   (size_q),
      .sgn    (sgn_q),
      .data   (ld_data)
   );

   // Enables are registered at accept so they are high exactly for the ACCESS cycle;
   // address/data registers only move on legal accesses and otherwise hold.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         size_q     <= SZ_B;
         off_q      <= '0;
         sgn_q      <= 1'b0;
         wen_q      <= 1'b0;
         misal_q    <= 1'b0;
         fault_q    <= 1'b0;
         rd_en      <= 1'b0;
         we_en      <= 1'b0;
         rd_addr    <= '0;
         we_addr    <= '0;
         we_data    <= '0;
         we_mask    <= '0;
         resp_rdata <= '0;
         resp_misal <= 1'b0;
         resp_fault <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               state   <= ST_ACCESS;
               size_q  <= sz_c;
               off_q   <= req_addr[2:0];
               sgn_q   <= req_signed;
               wen_q   <= req_wen;
               misal_q <= misal_c;
               fault_q <= fault_c;
               if (!misal_c && !fault_c) begin
                  rd_en <= !req_wen;
                  we_en <= req_wen;
                  if (req_wen) begin
                     we_addr <= req_addr;
                     we_data <= req_wdata;
                     we_mask <= size_to_mask(sz_c);
                  end else begin
                     rd_addr <= {req_addr[63:3], 3'b000};
                  end
               end
            end
            ST_ACCESS: begin
               state      <= ST_RESP;
               rd_en      <= 1'b0;
               we_en      <= 1'b0;
               resp_rdata <= (!wen_q && !misal_q && !fault_q) ? ld_data : 64'd0;
               resp_misal <= misal_q;
               resp_fault <= fault_q;
            end
            ST_RESP: if (resp_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed plus randomized self-checking bench for lsu_mem_master
module tb_lsu_mem_master;
   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam logic [63:0] SIZE = 64'h0800_0000;

   logic        clock = 1'b0, reset = 1'b0;
   logic        req_valid = 1'b0, req_wen = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
   logic [63:0] req_addr = '0, req_wdata = '0, mem_word = '0;
   logic [1:0]  req_size = '0;
   logic        req_ready, resp_valid, resp_misal, resp_fault, rd_en, we_en;
   logic [63:0] resp_rdata, rd_addr, we_addr, we_data;
   logic [7:0]  we_mask;
   int          n_chk = 0, n_fail = 0;
   logic [63:0] m_rd_addr = '0, m_we_addr = '0, m_we_data = '0;
   logic [7:0]  m_we_mask = '0;

   always #5 clock = ~clock;

   lsu_mem_master dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
      .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_misal(resp_misal), .resp_fault(resp_fault),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(mem_word),
      .we_en(we_en), .we_addr(we_addr), .we_data(we_data), .we_mask(we_mask)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_mem();
      chk("rd_addr", rd_addr, m_rd_addr);
      chk("we_addr", we_addr, m_we_addr);
      chk("we_data", we_data, m_we_data);
      chk("we_mask", {56'd0, we_mask}, {56'd0, m_we_mask});
   endtask

   // One full request/response transaction; hold = cycles resp_ready stays low.
   task automatic do_req(input bit wen, input logic [63:0] a, input int sz, input bit sg,
                         input logic [63:0] wd, input int hold);
      int          nb, w;
      bit          misal, fault, ok;
      logic [64:0] fin, lim;
      logic [63:0] m, v;
      nb    = 1 << sz;
      misal = (a % nb) != 0;
      fin   = {1'b0, a} + nb;
      lim   = {1'b0, BASE} + {1'b0, SIZE};
      fault = a < BASE || fin > lim;
      ok    = !misal && !fault;
      v     = 64'd0;
      if (!wen && ok) begin
         v = mem_word >> (8 * (a % 8));
         if (sz != 3) begin
            m = (64'd1 << (8 * nb)) - 64'd1;
            v = v & m;
            if (sg && v[8*nb-1]) v = v | ~m;
         end
      end
      w = 0;
      while (req_ready !== 1'b1 && w < 10) begin
         @(negedge clock);
         w++;
      end
      chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_wen = wen; req_addr = a; req_size = 2'(sz);
      req_signed = sg; req_wdata = wd;
      @(negedge clock);
      req_valid = 1'b0;
      if (ok && wen) begin
         m_we_addr = a;
         m_we_data = wd;
         m_we_mask = 8'((1 << nb) - 1);
      end
      if (ok && !wen) m_rd_addr = a & ~64'd7;
      chk("rd_en_access", {63'd0, rd_en}, {63'd0, ok && !wen});
      chk("we_en_access", {63'd0, we_en}, {63'd0, ok && wen});
      chk("req_ready_access", {63'd0, req_ready}, 64'd0);
      chk("resp_valid_access", {63'd0, resp_valid}, 64'd0);
      chk_mem();
      @(negedge clock);
      for (int i = 0; i <= hold; i++) begin
         chk("resp_valid", {63'd0, resp_valid}, 64'd1);
         chk("resp_rdata", resp_rdata, v);
         chk("resp_misal", {63'd0, resp_misal}, {63'd0, misal});
         chk("resp_fault", {63'd0, resp_fault}, {63'd0, fault});
         chk("rd_en_resp", {63'd0, rd_en}, 64'd0);
         chk("we_en_resp", {63'd0, we_en}, 64'd0);
         chk("req_ready_resp", {63'd0, req_ready}, 64'd0);
         chk_mem();
         if (i < hold) begin
            // a competing request that must not be taken while the response is pending
            req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE; req_size = 2'd0;
            @(negedge clock);
         end
      end
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0; req_valid = 1'b0;
      chk("resp_valid_retired", {63'd0, resp_valid}, 64'd0);
      chk("req_ready_retired", {63'd0, req_ready}, 64'd1);
      chk("no_spurious_en", {62'd0, rd_en, we_en}, 64'd0);
      chk_mem();
   endtask

   initial begin
      #1;
      chk("reset_req_ready", {63'd0, req_ready}, 64'd0);
      chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("reset_resp", {resp_rdata[61:0], resp_misal, resp_fault}, 64'd0);
      chk("reset_en", {62'd0, rd_en, we_en}, 64'd0);
      chk_mem();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("req_ready_release", {63'd0, req_ready}, 64'd1);

      mem_word = 64'h0000_8000_0000_0000;
      do_req(1'b0, 64'h8000_0005, 0, 1'b1, 64'd0, 0);
      chk("t1_rd_addr", rd_addr, 64'h8000_0000);
      do_req(1'b1, 64'h8000_0102, 1, 1'b0, 64'h1234, 0);
      chk("t2_we_mask", {56'd0, we_mask}, 64'h03);
      mem_word = 64'hDEAD_BEEF_CAFE_F00D;
      do_req(1'b0, 64'h8000_0002, 2, 1'b0, 64'd0, 0);
      do_req(1'b1, 64'h8800_0000, 3, 1'b0, 64'h1111_2222_3333_4444, 0);
      do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 3, 1'b0, 64'd0, 0);
      do_req(1'b0, 64'h87FF_FFF8, 3, 1'b1, 64'd0, 0);
      do_req(1'b0, 64'h87FF_FFFC, 2, 1'b1, 64'd0, 5);
      do_req(1'b0, 64'h7FFF_FFFF, 0, 1'b0, 64'd0, 1);

      // reset during the ACCESS cycle of a store
      @(negedge clock);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0040; req_size = 2'd3;
      req_wdata = 64'h0123_4567_89AB_CDEF;
      @(negedge clock);
      req_valid = 1'b0;
      chk("t6_we_en_before", {63'd0, we_en}, 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("t6_we_en_async", {63'd0, we_en}, 64'd0);
      chk("t6_resp_valid", {63'd0, resp_valid}, 64'd0);
      m_rd_addr = '0; m_we_addr = '0; m_we_data = '0; m_we_mask = '0;
      chk_mem();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("t6_idle_ready", {63'd0, req_ready}, 64'd1);
      chk("t6_no_resp", {63'd0, resp_valid}, 64'd0);
      chk("t6_no_en", {62'd0, rd_en, we_en}, 64'd0);

      for (int k = 0; k < 80; k++) begin
         int          sz, sel;
         logic [63:0] a;
         sz  = int'($urandom_range(0, 3));
         sel = int'($urandom_range(0, 7));
         a   = BASE + 64'($urandom_range(0, 32'h07FF_FFFF));
         if (sel < 4) a = a & ~(64'(1 << sz) - 64'd1);
         else if (sel == 5) a = {$urandom, $urandom};
         else if (sel == 6) a = BASE + SIZE - 64'(1 << sz) + 64'($urandom_range(0, 8)) - 64'd4;
         mem_word = {$urandom, $urandom};
         do_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
